// File: rtl/regfile_test_checker.sv
// regfile_test_checker: starts a core run, bounds it, scans the register file and streams mismatch records
// Ports:
//   clk_i, rst_ni                    clock, asynchronous active-low reset
//   run_i                            start request (accepted in IDLE/DONE)
//   exp_we_i/addr_i/data_i/check_i   expected-table write port (accepted in IDLE/DONE)
//   core_start_o, core_done_i        core control
//   rf_addr_o, rf_data_i             register-file read port (data one cycle after address)
//   mm_valid_o/ready_i/index_o/expected_o/actual_o  mismatch record stream
//   busy_o, done_o, passed_o, timed_out_o, mismatch_count_o  status
module regfile_test_checker #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 32,
  parameter int INDEX_BITS  = 5,
  parameter int TEST_LENGTH = 100,
  parameter int CNT_BITS    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  run_i,
  input  logic                  exp_we_i,
  input  logic [INDEX_BITS-1:0] exp_addr_i,
  input  logic [DATA_WIDTH-1:0] exp_data_i,
  input  logic                  exp_check_i,
  output logic                  core_start_o,
  input  logic                  core_done_i,
  output logic [INDEX_BITS-1:0] rf_addr_o,
  input  logic [DATA_WIDTH-1:0] rf_data_i,
  output logic                  mm_valid_o,
  input  logic                  mm_ready_i,
  output logic [INDEX_BITS-1:0] mm_index_o,
  output logic [DATA_WIDTH-1:0] mm_expected_o,
  output logic [DATA_WIDTH-1:0] mm_actual_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  passed_o,
  output logic                  timed_out_o,
  output logic [INDEX_BITS:0]   mismatch_count_o
);
  typedef enum logic [2:0] {IDLE, START, RUN, SCAN, CMP, REPORT, DONE} state_e;
  localparam logic [INDEX_BITS-1:0] LAST   = INDEX_BITS'(NUM_REGS - 1);
  localparam logic [CNT_BITS-1:0]   BUDGET = CNT_BITS'(TEST_LENGTH - 1);
  localparam logic [INDEX_BITS:0]   MAXC   = (INDEX_BITS + 1)'(NUM_REGS);
  state_e                  state_q;
  logic [CNT_BITS-1:0]     cnt_q;
  logic [INDEX_BITS-1:0]   idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   exp_q [NUM_REGS];
  logic [NUM_REGS-1:0]     chk_q;
  logic [INDEX_BITS:0]     count_q;
  logic                    core_start_q, mm_valid_q, done_q, timed_out_q, miss;
  logic [INDEX_BITS-1:0]   rf_addr_q, mm_index_q;
  logic [DATA_WIDTH-1:0]   mm_exp_q, mm_act_q;
  assign idx_d            = idx_q + 1'b1;
  assign miss             = chk_q[idx_q] && (rf_data_i != exp_q[idx_q]);
  assign busy_o           = (state_q != IDLE) && (state_q != DONE);
  assign passed_o         = done_q && (count_q == '0);
  assign core_start_o     = core_start_q;
  assign rf_addr_o        = rf_addr_q;
  assign mm_valid_o       = mm_valid_q;
  assign mm_index_o       = mm_index_q;
  assign mm_expected_o    = mm_exp_q;
  assign mm_actual_o      = mm_act_q;
  assign done_o           = done_q;
  assign timed_out_o      = timed_out_q;
  assign mismatch_count_o = count_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      count_q      <= '0;
      core_start_q <= 1'b0;
      mm_valid_q   <= 1'b0;
      done_q       <= 1'b0;
      timed_out_q  <= 1'b0;
      rf_addr_q    <= '0;
      mm_index_q   <= '0;
      mm_exp_q     <= '0;
      mm_act_q     <= '0;
      chk_q        <= '1;
      for (int k = 0; k < NUM_REGS; k++) exp_q[k] <= '0;
    end else begin
      core_start_q <= 1'b0;
      if (exp_we_i && !busy_o) begin
        exp_q[exp_addr_i] <= exp_data_i;
        chk_q[exp_addr_i] <= exp_check_i;
      end
      case (state_q)
        IDLE, DONE: if (run_i) begin
          state_q      <= START;
          core_start_q <= 1'b1;
          done_q       <= 1'b0;
          timed_out_q  <= 1'b0;
          count_q      <= '0;
          cnt_q        <= '0;
        end
        START: state_q <= RUN;
        RUN: begin
          cnt_q <= cnt_q + 1'b1;
          // core_done has priority over the budget, so timed_out only reflects a true timeout
          if (core_done_i || cnt_q == BUDGET) begin
            state_q     <= SCAN;
            timed_out_q <= !core_done_i;
            idx_q       <= '0;
            rf_addr_q   <= '0;
          end
        end
        SCAN: state_q <= CMP;
        CMP, REPORT: if (state_q == CMP && miss) begin
          state_q    <= REPORT;
          mm_valid_q <= 1'b1;
          mm_index_q <= idx_q;
          mm_exp_q   <= exp_q[idx_q];
          mm_act_q   <= rf_data_i;
          if (count_q != MAXC) count_q <= count_q + 1'b1;
        end else if (state_q == CMP || mm_ready_i) begin
          mm_valid_q <= 1'b0;
          if (idx_q == LAST) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q   <= SCAN;
            idx_q     <= idx_d;
            rf_addr_q <= idx_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_test_checker.sv
// tb_regfile_test_checker: directed scenarios for regfile_test_checker
module tb_regfile_test_checker;
  logic        clk = 0, rst_n = 0, run = 0, exp_we = 0, exp_check = 0, core_done = 0, mm_ready = 0;
  logic [4:0]  exp_addr = 0;
  logic [31:0] exp_data = 0, rf_data = 0;
  logic [31:0] rf [32];
  logic        core_start, mm_valid, busy, done, passed, timed_out;
  logic [4:0]  rf_addr, mm_index;
  logic [31:0] mm_expected, mm_actual;
  logic [5:0]  mm_count;
  int compared = 0, failed = 0, rec_n = 0, run_len = 0;
  logic [4:0]  r_idx [32];
  logic [31:0] r_exp [32], r_act [32];
  bit ever_valid;

  regfile_test_checker dut (
    .clk_i(clk), .rst_ni(rst_n), .run_i(run), .exp_we_i(exp_we), .exp_addr_i(exp_addr),
    .exp_data_i(exp_data), .exp_check_i(exp_check), .core_start_o(core_start), .core_done_i(core_done),
    .rf_addr_o(rf_addr), .rf_data_i(rf_data), .mm_valid_o(mm_valid), .mm_ready_i(mm_ready),
    .mm_index_o(mm_index), .mm_expected_o(mm_expected), .mm_actual_o(mm_actual), .busy_o(busy),
    .done_o(done), .passed_o(passed), .timed_out_o(timed_out), .mismatch_count_o(mm_count));

  always #5 clk = ~clk;
  always @(posedge clk) rf_data <= rf[rf_addr];

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic c);
    @(negedge clk); exp_we = 1; exp_addr = a; exp_data = d; exp_check = c;
    @(negedge clk); exp_we = 0;
  endtask

  task automatic set_reg(input logic [4:0] a, input logic [31:0] d);
    wr(a, d, 1'b1);
    rf[a] = d;
  endtask

  // done_at = RUN cycle on which core_done is raised (0 = never); stall = ready-low cycles per record
  task automatic do_run(input int done_at, input int stall, input bit poke);
    int n, wc;
    bit inrec, hs;
    logic [4:0] ci; logic [31:0] ce, ca;
    rec_n = 0; ever_valid = 0; run_len = 0; inrec = 0; hs = 0; wc = 0;
    @(negedge clk); run = 1;
    @(negedge clk); run = 0;
    compared++; if (core_start !== 1'b1) begin failed++; $display("FAIL core_start_pulse got %b want 1", core_start); end
    @(negedge clk);
    compared++; if (core_start !== 1'b0) begin failed++; $display("FAIL core_start_width got %b want 0", core_start); end
    if (done_at > 0) begin
      for (int k = 1; k < done_at; k++) @(negedge clk);
      core_done = 1;
      @(negedge clk); core_done = 0;
      run_len = done_at;
    end else begin
      n = 1;
      while (timed_out !== 1'b1 && n <= 105) begin
        run = poke && n == 5; exp_we = run; exp_addr = 20; exp_data = 1; exp_check = 1;
        @(negedge clk); n++;
      end
      run = 0; exp_we = 0;
      run_len = n - 1;
    end
    for (int c = 0; c < 3000 && done !== 1'b1; c++) begin
      if (hs) begin
        compared++; if (mm_valid !== 1'b0) begin failed++; $display("FAIL mm_valid_drop got %b want 0", mm_valid); end
        hs = 0; mm_ready = 0;
      end else if (mm_valid === 1'b1) begin
        ever_valid = 1;
        if (!inrec) begin
          inrec = 1; wc = 0; ci = mm_index; ce = mm_expected; ca = mm_actual;
        end else begin
          compared++;
          if ({mm_index, mm_expected, mm_actual} !== {ci, ce, ca}) begin
            failed++; $display("FAIL mm_stable got %0d/%h/%h want %0d/%h/%h", mm_index, mm_expected, mm_actual, ci, ce, ca);
          end
          wc++;
        end
        if (wc >= stall) begin
          mm_ready = 1; hs = 1; inrec = 0;
          r_idx[rec_n] = ci; r_exp[rec_n] = ce; r_act[rec_n] = ca; rec_n++;
        end
      end
      @(negedge clk);
    end
    mm_ready = 0;
    compared++; if (done !== 1'b1) begin failed++; $display("FAIL done_timeout got %b want 1", done); end
  endtask

  task automatic test_reset;
    #12;
    compared++;
    if ({core_start, mm_valid, busy, done, passed, timed_out, rf_addr, mm_index, mm_expected, mm_actual, mm_count} !== '0) begin
      failed++; $display("FAIL reset_outputs got nonzero want all zero");
    end
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_ori_pass;
    for (int i = 0; i < 32; i++) rf[i] = 0;
    set_reg(11, 32'h0000_1000); set_reg(12, 32'h8000_0000); set_reg(13, 32'hffff_f000);
    set_reg(14, 32'h0000_0001); set_reg(15, 32'hffff_ffff); set_reg(16, 32'h0000_1400);
    set_reg(17, 32'hffff_f000);
    do_run(40, 0, 0);
    compared++; if (passed !== 1'b1) begin failed++; $display("FAIL ori_passed got %b want 1", passed); end
    compared++; if (mm_count !== 6'd0) begin failed++; $display("FAIL ori_count got %0d want 0", mm_count); end
    compared++; if (timed_out !== 1'b0) begin failed++; $display("FAIL ori_timed_out got %b want 0", timed_out); end
    compared++; if (ever_valid) begin failed++; $display("FAIL ori_mm_valid got 1 want never"); end
    compared++; if (busy !== 1'b0) begin failed++; $display("FAIL ori_busy got %b want 0", busy); end
  endtask

  task automatic test_single_mismatch;
    rf[12] = 32'h0;
    do_run(40, 0, 0);
    compared++; if (rec_n !== 1) begin failed++; $display("FAIL mm1_records got %0d want 1", rec_n); end
    compared++;
    if ({r_idx[0], r_exp[0], r_act[0]} !== {5'd12, 32'h8000_0000, 32'h0}) begin
      failed++; $display("FAIL mm1_record got %0d/%h/%h want 12/80000000/00000000", r_idx[0], r_exp[0], r_act[0]);
    end
    compared++; if (passed !== 1'b0) begin failed++; $display("FAIL mm1_passed got %b want 0", passed); end
    compared++; if (mm_count !== 6'd1) begin failed++; $display("FAIL mm1_count got %0d want 1", mm_count); end
  endtask

  task automatic test_mask_skip;
    wr(12, 32'h8000_0000, 1'b0);
    do_run(40, 0, 0);
    compared++; if (passed !== 1'b1) begin failed++; $display("FAIL mask_passed got %b want 1", passed); end
    compared++; if (ever_valid) begin failed++; $display("FAIL mask_mm_valid got 1 want never"); end
  endtask

  task automatic test_timeout;
    set_reg(12, 32'h8000_0000);
    do_run(0, 0, 1);
    compared++; if (run_len !== 100) begin failed++; $display("FAIL tmo_run_len got %0d want 100", run_len); end
    compared++; if (timed_out !== 1'b1) begin failed++; $display("FAIL tmo_flag got %b want 1", timed_out); end
    compared++; if (passed !== 1'b1) begin failed++; $display("FAIL tmo_busy_writes got passed=%b want 1", passed); end
    compared++; if (done !== 1'b1) begin failed++; $display("FAIL tmo_done got %b want 1", done); end
  endtask

  task automatic test_backpressure;
    rf[3] = 32'h33; rf[7] = 32'h77;
    do_run(10, 5, 0);
    compared++; if (rec_n !== 2) begin failed++; $display("FAIL bp_records got %0d want 2", rec_n); end
    compared++;
    if ({r_idx[0], r_exp[0], r_act[0]} !== {5'd3, 32'h0, 32'h33}) begin
      failed++; $display("FAIL bp_rec0 got %0d/%h/%h want 3/00000000/00000033", r_idx[0], r_exp[0], r_act[0]);
    end
    compared++;
    if ({r_idx[1], r_exp[1], r_act[1]} !== {5'd7, 32'h0, 32'h77}) begin
      failed++; $display("FAIL bp_rec1 got %0d/%h/%h want 7/00000000/00000077", r_idx[1], r_exp[1], r_act[1]);
    end
    compared++; if (mm_count !== 6'd2) begin failed++; $display("FAIL bp_count got %0d want 2", mm_count); end
    compared++; if (timed_out !== 1'b0) begin failed++; $display("FAIL bp_timed_out got %b want 0", timed_out); end
    rf[3] = 0; rf[7] = 0;
  endtask

  task automatic test_reset_abort;
    bit found = 0;
    wr(12, 32'h8000_0000, 1'b0);
    @(negedge clk); run = 1;
    @(negedge clk); run = 0;
    for (int c = 0; c < 400 && !found; c++) begin @(negedge clk); if (rf_addr === 5'd9) found = 1; end
    compared++; if (!found) begin failed++; $display("FAIL abort_reach_x9 got no scan want x9"); end
    @(negedge clk); #1 rst_n = 0; #1;
    compared++;
    if ({core_start, mm_valid, busy, done, passed, timed_out, rf_addr, mm_index, mm_expected, mm_actual, mm_count} !== '0) begin
      failed++; $display("FAIL abort_outputs got nonzero want all zero");
    end
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 32; i++) rf[i] = 0;
    do_run(3, 0, 0);
    compared++; if (passed !== 1'b1) begin failed++; $display("FAIL abort_zero_pass got %b want 1", passed); end
    compared++; if (rec_n !== 0) begin failed++; $display("FAIL abort_zero_records got %0d want 0", rec_n); end
    rf[12] = 32'h5;
    do_run(3, 0, 0);
    compared++; if (rec_n !== 1) begin failed++; $display("FAIL abort_mask_records got %0d want 1", rec_n); end
    compared++;
    if ({r_idx[0], r_exp[0], r_act[0]} !== {5'd12, 32'h0, 32'h5}) begin
      failed++; $display("FAIL abort_mask_record got %0d/%h/%h want 12/00000000/00000005", r_idx[0], r_exp[0], r_act[0]);
    end
    compared++; if (mm_count !== 6'd1) begin failed++; $display("FAIL abort_mask_count got %0d want 1", mm_count); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 0;
    test_reset;
    test_ori_pass;
    test_single_mismatch;
    test_mask_skip;
    test_timeout;
    test_backpressure;
    test_reset_abort;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule
